// File: rtl/spi_burst_pkg.sv
// Opcode constants and FSM state encoding shared by the burst SPI RAM slave.
package spi_burst_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHK_CMD = 3'd1,
        ST_OP      = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_RD_ADDR = 3'd5,
        ST_RD_DATA = 3'd6
    } state_t;

endpackage

// File: rtl/spi_burst_ram.sv
// Private word RAM: one synchronous write port and one registered read port.
module spi_burst_ram #(
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_SIZE  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_SIZE-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_SIZE-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Write port; the array is deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, sampled every cycle.
    always_ff @(posedge clk) begin
        rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/spi_burst_ram_slave.sv
// SPI slave with private RAM: opcode decode, address load, auto-increment
// burst write and gap-free burst read, plus a pulse when a frame is cut short.
module spi_burst_ram_slave #(
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_SIZE  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic frame_abort
);
    import spi_burst_pkg::*;

    localparam int SW = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH;
    localparam int CW = $clog2(SW);
    localparam logic [CW-1:0]        ADDR_LAST = CW'(ADDR_SIZE - 1);
    localparam logic [CW-1:0]        DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
    localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = ADDR_SIZE'(1);

    state_t                state_r, state_s;
    logic                  op_hi_r, addr_done_r, primed_r, miso_r, abort_r;
    logic [SW-2:0]         rx_shift_r;
    logic [SW-1:0]         rx_word_s;
    logic [CW-1:0]         bit_cnt_r;
    logic [DATA_WIDTH-1:0] tx_shift_r, ram_q_s;
    logic [ADDR_SIZE-1:0]  wr_addr_r, rd_addr_r, ram_raddr_s;
    logic                  data_state_s, last_bit_s, ram_we_s, abort_s;

    assign rx_word_s   = {rx_shift_r, MOSI};
    assign MISO        = miso_r;
    assign frame_abort = abort_r;

    spi_burst_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we_s),
        .waddr(wr_addr_r),
        .wdata(rx_word_s[DATA_WIDTH-1:0]),
        .raddr(ram_raddr_s),
        .rdata(ram_q_s)
    );

    // Word-boundary detection, RAM strobes and truncated-frame detection.
    always_comb begin
        data_state_s = (state_r == ST_WR_DATA) || (state_r == ST_RD_DATA);
        last_bit_s   = (bit_cnt_r == (data_state_s ? DATA_LAST : ADDR_LAST));
        ram_we_s     = (state_r == ST_WR_DATA) && !SS_n && last_bit_s;
        // On the last bit of a read word, prefetch the following word so MISO has no gap.
        if ((state_r == ST_RD_DATA) && primed_r && last_bit_s) begin
            ram_raddr_s = rd_addr_r + ADDR_ONE;
        end else begin
            ram_raddr_s = rd_addr_r;
        end
        if ((state_r == ST_IDLE) || !SS_n) begin
            abort_s = 1'b0;
        end else if ((state_r == ST_CHK_CMD) || (state_r == ST_OP)) begin
            abort_s = 1'b1;
        end else begin
            abort_s = (bit_cnt_r != {CW{1'b0}});
        end
    end

    // Next-state logic; SS_n high returns any active state to IDLE.
    always_comb begin
        state_s = state_r;
        if (state_r == ST_IDLE) begin
            state_s = SS_n ? ST_IDLE : ST_CHK_CMD;
        end else if (SS_n) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_CHK_CMD: state_s = ST_OP;
                ST_OP: begin
                    case ({op_hi_r, MOSI})
                        OP_WR_ADDR: state_s = ST_WR_ADDR;
                        OP_WR_DATA: state_s = ST_WR_DATA;
                        OP_RD_ADDR: state_s = ST_RD_ADDR;
                        OP_RD_DATA: state_s = ST_RD_DATA;
                        default:    state_s = ST_IDLE;
                    endcase
                end
                default: state_s = state_r;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Shift/bit counters, address registers and MISO serialiser.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_hi_r     <= 1'b0;
            addr_done_r <= 1'b0;
            primed_r    <= 1'b0;
            miso_r      <= 1'b0;
            abort_r     <= 1'b0;
            rx_shift_r  <= {(SW-1){1'b0}};
            tx_shift_r  <= {DATA_WIDTH{1'b0}};
            bit_cnt_r   <= {CW{1'b0}};
            wr_addr_r   <= {ADDR_SIZE{1'b0}};
            rd_addr_r   <= {ADDR_SIZE{1'b0}};
        end else begin
            abort_r <= abort_s;
            if ((state_r == ST_IDLE) || SS_n) begin
                miso_r      <= 1'b0;
                bit_cnt_r   <= {CW{1'b0}};
                addr_done_r <= 1'b0;
                primed_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_CHK_CMD: op_hi_r <= MOSI;
                    ST_WR_ADDR, ST_RD_ADDR: begin
                        if (!addr_done_r) begin
                            rx_shift_r <= rx_word_s[SW-2:0];
                            if (last_bit_s) begin
                                bit_cnt_r   <= {CW{1'b0}};
                                addr_done_r <= 1'b1;
                                if (state_r == ST_WR_ADDR) begin
                                    wr_addr_r <= rx_word_s[ADDR_SIZE-1:0];
                                end else begin
                                    rd_addr_r <= rx_word_s[ADDR_SIZE-1:0];
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + CNT_ONE;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        rx_shift_r <= rx_word_s[SW-2:0];
                        if (last_bit_s) begin
                            bit_cnt_r <= {CW{1'b0}};
                            wr_addr_r <= wr_addr_r + ADDR_ONE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        end
                    end
                    ST_RD_DATA: begin
                        // First cycle is the RAM turnaround; serialisation starts after it.
                        if (!primed_r) begin
                            primed_r <= 1'b1;
                        end else begin
                            if (bit_cnt_r == {CW{1'b0}}) begin
                                miso_r     <= ram_q_s[DATA_WIDTH-1];
                                tx_shift_r <= {ram_q_s[DATA_WIDTH-2:0], 1'b0};
                            end else begin
                                miso_r     <= tx_shift_r[DATA_WIDTH-1];
                                tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
                            end
                            if (last_bit_s) begin
                                bit_cnt_r <= {CW{1'b0}};
                                rd_addr_r <= rd_addr_r + ADDR_ONE;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + CNT_ONE;
                            end
                        end
                    end
                    default: miso_r <= 1'b0;
                endcase
            end
        end
    end

endmodule
